jt49_cmdseq: RTL and testbench
==============================

JT49_CMDSEQ -- requirements
Module: jt49_cmdseq

Interface
REQ-001 SHALL have parameter WAIT_SHIFT, default 8: left shift applied to the wait-command operand to form the wait length in cen ticks.
REQ-002 SHALL have parameter CW, default 20: width of the wait counter; CW >= 8+WAIT_SHIFT.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port cen, input, 1: clock enable that advances only the wait counter.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins or restarts sequencing.
REQ-007 SHALL have port abort, input, 1: one-cycle pulse that returns the block to IDLE.
REQ-008 SHALL have port cmd, input, 12: command word {op[11:8], data[7:0]}.
REQ-009 SHALL have port cmd_valid, input, 1: cmd is valid.
REQ-010 SHALL have port cmd_ready, output, 1: block accepts cmd this cycle.
REQ-011 SHALL have port addr, output, 4: PSG register address.
REQ-012 SHALL have port din, output, 8: PSG write data.
REQ-013 SHALL have port wr_n, output, 1: PSG write strobe, active-low.
REQ-014 SHALL have port cs_n, output, 1: PSG chip select, active-low.
REQ-015 SHALL have port busy, output, 1: high in FETCH, WRITE and WAIT.
REQ-016 SHALL have port done, output, 1: high in DONE.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WRITE, WAIT and DONE.
REQ-018 SHALL drive cmd_ready=1 only in FETCH; a command is accepted on cmd_valid&cmd_ready, with no combinational path from cmd_valid to cmd_ready.
REQ-019 SHALL decode op 0x0-0xD on acceptance as follows: register addr<=op and din<=data, then go to WRITE.
REQ-020 SHALL, in WRITE, drive wr_n=0 and cs_n=0 for exactly one clk cycle, then go to FETCH; wr_n and cs_n SHALL be 1 in every other state.
REQ-021 SHALL decode op 0xF as a wait: load counter with data<<WAIT_SHIFT; if the loaded value is 0, stay in FETCH, otherwise go to WAIT.
REQ-022 SHALL, in WAIT, decrement the counter only when cen=1, and go to FETCH on the cen cycle where the counter goes from 1 to 0.
REQ-023 SHALL decode op 0xE as end of sequence and go to DONE.
REQ-024 SHALL, in DONE, hold done=1 until start or abort.
REQ-025 SHALL, on start in IDLE or DONE, go to FETCH on the next cycle; start in FETCH, WRITE or WAIT SHALL be ignored.
REQ-026 SHALL, on abort in any state, go to IDLE next cycle with wr_n=1 and cs_n=1 and the counter cleared; abort SHALL win over a simultaneous start or command acceptance.
REQ-027 SHALL leave addr and din unchanged except on acceptance of op 0x0-0xD.
REQ-028 SHALL give a throughput of one register write per 2 clk cycles when cmd_valid is held high.

Reset
REQ-029 SHALL, on rst, set state=IDLE, addr=0, din=0, wr_n=1, cs_n=1, cmd_ready=0, busy=0, done=0 and counter=0; rst SHALL override every other input, including mid-WRITE and mid-WAIT.

Configuration
REQ-030 SHALL, with macro JT49_CMDSEQ_CNT_EN defined, add output wr_count, 16 bits: the number of completed WRITE cycles since the last start or rst, wrapping 0xFFFF->0.
REQ-031 SHALL, without JT49_CMDSEQ_CNT_EN, have neither the port nor its logic.

Structure
REQ-032 SHALL place the opcode constants OP_END=4'hE and OP_WAIT=4'hF, and the FSM state typedef, in shared package jt49_cmdseq_pkg.
REQ-033 SHALL implement the loadable, cen-gated down-counter as sub-module jt49_cmdseq_wait, with ports load, value, cen and zero.

Verification
REQ-034 SHALL verify: start, then cmd 0x002 with valid held -> one cycle of wr_n=0 and cs_n=0 with addr=0 and din=0x02, followed by cmd_ready=1 the next cycle.
REQ-035 SHALL verify: cmd 0xF01 with cen=1 every cycle -> WAIT lasting exactly 256 cycles, with cmd_ready=0 throughout and no write.
REQ-036 SHALL verify: cmd 0xF00 -> no WAIT entered and the next command accepted on the following cycle.
REQ-037 SHALL verify: cmd 0xF01 with cen=1 every 4th cycle -> 1024 cycles in WAIT.
REQ-038 SHALL verify: cmd 0xEFF -> done=1 and busy=0 held; a later start -> FETCH with done=0.
REQ-039 SHALL verify: abort during WAIT, and rst asserted while WRITE is active -> IDLE next cycle with wr_n=1; with JT49_CMDSEQ_CNT_EN, 14 writes -> wr_count=14.

Source files
------------

// File: rtl/jt49_cmdseq_pkg.sv
// Shared opcode constants, FSM state type and opcode helper for the command sequencer.
package jt49_cmdseq_pkg;

    localparam logic [3:0] OP_END  = 4'hE;
    localparam logic [3:0] OP_WAIT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Opcodes 0x0-0xD address a PSG register directly.
    function automatic logic is_reg_op(input logic [3:0] op);
        return op <= 4'hD;
    endfunction

endpackage

// File: rtl/jt49_cmdseq_wait.sv
// Loadable down-counter advanced only on cen; flags the tick that takes it from 1 to 0.
// Latency: load visible next cycle; expire is combinational on cen with count==1.
// Backpressure: none, it just counts.
module jt49_cmdseq_wait #(
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] value,
    input  logic          cen,
    output logic          zero,
    output logic          expire
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (load)
            r_cnt <= value;
        else if (cen && r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
    end

    assign zero   = (r_cnt == '0);
    assign expire = cen && (r_cnt == CW'(1));

endmodule

// File: rtl/jt49_cmdseq.sv
// Command sequencer feeding JT49 PSG register writes; optional wr_count via JT49_CMDSEQ_CNT_EN.
// Latency: outputs registered, one register write per 2 clk with cmd_valid held.
// Backpressure: cmd_ready is a registered FETCH flag, independent of cmd_valid.
module jt49_cmdseq
    import jt49_cmdseq_pkg::*;
#(
    parameter int WAIT_SHIFT = 8,
    parameter int CW         = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [3:0]  addr,
    output logic [7:0]  din,
    output logic        wr_n,
    output logic        cs_n,
    output logic        busy,
`ifdef JT49_CMDSEQ_CNT_EN
    output logic [15:0] wr_count,
`endif
    output logic        done
);

    state_t        r_state;
    state_t        w_nxt;
    logic          r_cmd_ready, r_wr_n, r_cs_n, r_busy, r_done;
    logic [3:0]    r_addr;
    logic [7:0]    r_din;
    logic [3:0]    w_op;
    logic [7:0]    w_data;
    logic [CW-1:0] w_wait_val;
    logic          w_accept, w_wait_load, w_cnt_clr, w_zero, w_expire;

    assign w_op        = cmd[11:8];
    assign w_data      = cmd[7:0];
    assign w_wait_val  = {{(CW-8){1'b0}}, w_data} << WAIT_SHIFT;
    assign w_accept    = r_cmd_ready && cmd_valid && !abort;
    assign w_wait_load = w_accept && (w_op == OP_WAIT);
    assign w_cnt_clr   = rst || abort;

    jt49_cmdseq_wait #(.CW(CW)) u_wait (
        .clk    (clk),
        .rst    (w_cnt_clr),
        .load   (w_wait_load),
        .value  (w_wait_val),
        .cen    (cen),
        .zero   (w_zero),
        .expire (w_expire)
    );

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_nxt = ST_FETCH;
            ST_FETCH: if (cmd_valid) begin
                if (is_reg_op(w_op))
                    w_nxt = ST_WRITE;
                else if (w_op == OP_END)
                    w_nxt = ST_DONE;
                else if (w_wait_val != '0)
                    w_nxt = ST_WAIT;
            end
            ST_WRITE: w_nxt = ST_FETCH;
            // zero only guards against a counter cleared under us; expire is the normal exit
            ST_WAIT:  if (w_expire || w_zero) w_nxt = ST_FETCH;
            default:  w_nxt = ST_IDLE;
        endcase
        if (abort) w_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_wr_n      <= 1'b1;
            r_cs_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
        end else begin
            r_state     <= w_nxt;
            r_cmd_ready <= (w_nxt == ST_FETCH);
            r_wr_n      <= (w_nxt != ST_WRITE);
            r_cs_n      <= (w_nxt != ST_WRITE);
            r_busy      <= (w_nxt == ST_FETCH) || (w_nxt == ST_WRITE) || (w_nxt == ST_WAIT);
            r_done      <= (w_nxt == ST_DONE);
            if (w_accept && is_reg_op(w_op)) begin
                r_addr <= w_op;
                r_din  <= w_data;
            end
        end
    end

`ifdef JT49_CMDSEQ_CNT_EN
    logic [15:0] r_wr_count;
    logic        w_start_acc;

    assign w_start_acc = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk) begin
        if (rst || w_start_acc)
            r_wr_count <= '0;
        else if (r_state == ST_WRITE)
            r_wr_count <= r_wr_count + 16'd1;
    end

    assign wr_count = r_wr_count;
`endif

    assign cmd_ready = r_cmd_ready;
    assign addr      = r_addr;
    assign din       = r_din;
    assign wr_n      = r_wr_n;
    assign cs_n      = r_cs_n;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_jt49_cmdseq.sv
// Directed bench for jt49_cmdseq: vector table plus hand sequences for WAIT, abort, rst and throughput.
module tb_jt49_cmdseq;

    logic        clk = 1'b0;
    logic        rst, cen, start, abort, cmd_valid;
    logic [11:0] cmd;
    logic        cmd_ready, wr_n, cs_n, busy, done;
    logic [3:0]  addr;
    logic [7:0]  din;
`ifdef JT49_CMDSEQ_CNT_EN
    logic [15:0] wr_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jt49_cmdseq dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .start     (start),
        .abort     (abort),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .addr      (addr),
        .din       (din),
        .wr_n      (wr_n),
        .cs_n      (cs_n),
        .busy      (busy),
`ifdef JT49_CMDSEQ_CNT_EN
        .wr_count  (wr_count),
`endif
        .done      (done)
    );

    typedef struct {
        logic        st, ab, vld;
        logic [11:0] c;
        logic        rdy, wrn;
        logic [3:0]  a;
        logic [7:0]  d;
        logic        b, dn;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(input logic st, ab, vld, input logic [11:0] c,
                                input logic rdy, wrn, input logic [3:0] a,
                                input logic [7:0] d, input logic b, dn);
        vec_t v;
        v.st = st; v.ab = ab; v.vld = vld; v.c = c;
        v.rdy = rdy; v.wrn = wrn; v.a = a; v.d = d; v.b = b; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a wait command from FETCH and count cycles spent in WAIT.
    // period 1: cen every cycle; otherwise cen on every period-th WAIT cycle.
    task automatic wait_run(input logic [11:0] c, input int period,
                            output int n, output logic saw_wr);
        cmd = c; cmd_valid = 1'b1; cen = (period == 1);
        tick();
        cmd_valid = 1'b0;
        n = 0; saw_wr = 1'b0;
        while (busy && !cmd_ready && n < 5000) begin
            n++;
            if (!wr_n) saw_wr = 1'b1;
            cen = (period == 1) ? 1'b1 : ((n % period) == 0);
            tick();
        end
        cen = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic saw_wr;
        int   writes;

        vt[0]  = mk(0,0,0,12'h000, 0,1,4'h0,8'h00,0,0);
        vt[1]  = mk(1,0,0,12'h000, 1,1,4'h0,8'h00,1,0);
        vt[2]  = mk(0,0,1,12'h002, 0,0,4'h0,8'h02,1,0);
        vt[3]  = mk(0,0,1,12'h002, 1,1,4'h0,8'h02,1,0);
        vt[4]  = mk(0,0,1,12'h5A7, 0,0,4'h5,8'hA7,1,0);
        vt[5]  = mk(1,0,0,12'h000, 1,1,4'h5,8'hA7,1,0);
        vt[6]  = mk(1,0,0,12'h000, 1,1,4'h5,8'hA7,1,0);
        vt[7]  = mk(0,0,1,12'hF00, 1,1,4'h5,8'hA7,1,0);
        vt[8]  = mk(0,0,1,12'hD3C, 0,0,4'hD,8'h3C,1,0);
        vt[9]  = mk(0,0,0,12'h000, 1,1,4'hD,8'h3C,1,0);
        vt[10] = mk(0,0,1,12'hEFF, 0,1,4'hD,8'h3C,0,1);
        vt[11] = mk(0,0,0,12'h000, 0,1,4'hD,8'h3C,0,1);
        vt[12] = mk(0,0,1,12'h1FF, 0,1,4'hD,8'h3C,0,1);
        vt[13] = mk(1,0,0,12'h000, 1,1,4'hD,8'h3C,1,0);
        vt[14] = mk(0,1,1,12'h007, 0,1,4'hD,8'h3C,0,0);
        vt[15] = mk(1,1,0,12'h000, 0,1,4'hD,8'h3C,0,0);
        vt[16] = mk(1,0,0,12'h000, 1,1,4'hD,8'h3C,1,0);
        vt[17] = mk(0,0,1,12'hE00, 0,1,4'hD,8'h3C,0,1);
        vt[18] = mk(0,1,0,12'h000, 0,1,4'hD,8'h3C,0,0);

        rst = 1'b1; cen = 1'b0; start = 1'b0; abort = 1'b0; cmd_valid = 1'b0; cmd = '0;
        tick(); tick();
        chk("rst.ready", cmd_ready, 0);
        chk("rst.wr_n",  wr_n, 1);
        chk("rst.cs_n",  cs_n, 1);
        chk("rst.addr",  addr, 0);
        chk("rst.din",   din, 0);
        chk("rst.busy",  busy, 0);
        chk("rst.done",  done, 0);
        rst = 1'b0;

        foreach (vt[i]) begin
            start = vt[i].st; abort = vt[i].ab; cmd_valid = vt[i].vld; cmd = vt[i].c;
            tick();
            chk($sformatf("v%0d.ready", i), cmd_ready, vt[i].rdy);
            chk($sformatf("v%0d.wr_n", i),  wr_n, vt[i].wrn);
            chk($sformatf("v%0d.cs_n", i),  cs_n, vt[i].wrn);
            chk($sformatf("v%0d.addr", i),  addr, vt[i].a);
            chk($sformatf("v%0d.din", i),   din, vt[i].d);
            chk($sformatf("v%0d.busy", i),  busy, vt[i].b);
            chk($sformatf("v%0d.done", i),  done, vt[i].dn);
        end
        start = 1'b0; abort = 1'b0; cmd_valid = 1'b0;

        // WAIT 0x01 << 8 with cen every cycle
        start = 1'b1; tick(); start = 1'b0;
        wait_run(12'hF01, 1, n, saw_wr);
        chk("wait256.len", n, 256);
        chk("wait256.nowrite", saw_wr, 0);
        chk("wait256.ready_after", cmd_ready, 1);

        // Same wait with cen on every 4th cycle
        wait_run(12'hF01, 4, n, saw_wr);
        chk("wait1024.len", n, 1024);
        chk("wait1024.nowrite", saw_wr, 0);

        // Abort in the middle of a WAIT
        cmd = 12'hF05; cmd_valid = 1'b1; cen = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        chk("abort.in_wait_busy", busy, 1);
        chk("abort.in_wait_ready", cmd_ready, 0);
        abort = 1'b1; tick(); abort = 1'b0; cen = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.wr_n", wr_n, 1);
        chk("abort.ready", cmd_ready, 0);
        chk("abort.done", done, 0);

        // rst while WRITE is active
        start = 1'b1; tick(); start = 1'b0;
        cmd = 12'h3AA; cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
        chk("rstw.in_write_wr_n", wr_n, 0);
        chk("rstw.in_write_addr", addr, 4'h3);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstw.wr_n", wr_n, 1);
        chk("rstw.cs_n", cs_n, 1);
        chk("rstw.addr", addr, 0);
        chk("rstw.din",  din, 0);
        chk("rstw.busy", busy, 0);

        // Held cmd_valid: 28 cycles give 14 writes
        start = 1'b1; tick(); start = 1'b0;
        cmd = 12'h1C3; cmd_valid = 1'b1; writes = 0;
        for (int k = 0; k < 28; k++) begin
            tick();
            if (!wr_n) writes++;
        end
        cmd_valid = 1'b0;
        chk("tput.writes", writes, 14);
        chk("tput.din", din, 8'hC3);
`ifdef JT49_CMDSEQ_CNT_EN
        chk("cnt.wr_count", wr_count, 16'd14);
        start = 1'b1; abort = 1'b1; tick(); abort = 1'b0;
        tick(); start = 1'b0;
        chk("cnt.cleared", wr_count, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
